// File: rtl/srt_frame_ctrl.sv
// Frame sequencer for the SRT/CORDIC point datapath.
// Header/vector parsing, latency tracking and output credit throttle.
module srt_frame_ctrl #(
   parameter int PIPE_LAT  = 46,
   parameter int SRT_LAT   = 6,
   parameter int MAT_BEATS = 3,
   parameter int CREDITS   = 64,
   parameter int CNT_W     = 16
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             s_tvalid,
   input  logic             s_tlast,
   output logic             s_tready,
   output logic             mat_we,
   output logic [3:0]       mat_idx,
   output logic             vec_valid,
   output logic             ref_we,
   output logic [1:0]       ref_idx,
   output logic             out_valid,
   output logic             out_last,
   input  logic             fifo_pop,
   output logic             frame_done,
   output logic             err_short,
   output logic [CNT_W-1:0] vec_count
);

   localparam int BW  = (MAT_BEATS > 1) ? $clog2(MAT_BEATS) : 1;
   localparam int IFW = $clog2(CREDITS + 1);
   localparam logic [IFW-1:0] CRED_L    = IFW'(CREDITS);
   localparam logic [BW-1:0]  LAST_BEAT = BW'(MAT_BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_STREAM,
      S_DRAIN
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [BW-1:0]            r_beat;
   logic [CNT_W-1:0]         r_vec_count;
   logic [1:0]               r_tag;
   logic [IFW-1:0]           r_inflight;
   logic [PIPE_LAT-1:0]      r_vld;
   logic [PIPE_LAT-1:0]      r_lst;
   logic [SRT_LAT-1:0]       r_ref_vld;
   logic [SRT_LAT-1:0][1:0]  r_ref_tag;

   logic w_hdr;
   logic w_ready;
   logic w_hs;
   logic w_first;
   logic w_drained;
   logic w_tag_vld;
   logic w_inc;
   logic w_dec;

   assign w_hdr   = (r_state == S_IDLE) || (r_state == S_LOAD);
   // Credit check uses only the registered count, never fifo_pop.
   assign w_ready = ~areset &
                    (w_hdr ||
                     ((r_state == S_STREAM) && (r_inflight < CRED_L)));
   assign w_hs    = s_tvalid & w_ready;
   assign w_first = w_hs && (r_state == S_IDLE);
   assign w_drained = (r_vld == '0);

   always_comb begin
      w_next     = r_state;
      mat_we     = 1'b0;
      vec_valid  = 1'b0;
      err_short  = 1'b0;
      frame_done = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_hs) begin
               mat_we = 1'b1;
               if (s_tlast) begin
                  err_short = 1'b1;
               end else if (MAT_BEATS == 1) begin
                  w_next = S_STREAM;
               end else begin
                  w_next = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (w_hs) begin
               mat_we = 1'b1;
               if (s_tlast) begin
                  err_short = 1'b1;
                  w_next    = S_IDLE;
               end else if (r_beat == LAST_BEAT) begin
                  w_next = S_STREAM;
               end
            end
         end
         S_STREAM: begin
            if (w_hs) begin
               vec_valid = 1'b1;
               if (s_tlast) begin
                  w_next = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (w_drained) begin
               frame_done = 1'b1;
               w_next     = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_beat <= '0;
      end else if (mat_we) begin
         if (err_short || (w_next == S_STREAM)) begin
            r_beat <= '0;
         end else begin
            r_beat <= r_beat + 1'b1;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_vec_count <= '0;
      end else if (w_first) begin
         r_vec_count <= '0;
      end else if (vec_valid && (r_vec_count != '1)) begin
         r_vec_count <= r_vec_count + 1'b1;
      end
   end

   // Only the first three vectors of a frame carry a reference tag.
   assign w_tag_vld = vec_valid && (r_tag != 2'd3);

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_tag <= '0;
      end else if (w_first) begin
         r_tag <= '0;
      end else if (w_tag_vld) begin
         r_tag <= r_tag + 1'b1;
      end
   end

   assign w_inc = vec_valid;
   assign w_dec = fifo_pop && (r_inflight != '0);

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_inflight <= '0;
      end else if (w_inc && !w_dec) begin
         r_inflight <= r_inflight + 1'b1;
      end else if (!w_inc && w_dec) begin
         r_inflight <= r_inflight - 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_vld     <= '0;
         r_lst     <= '0;
         r_ref_vld <= '0;
         r_ref_tag <= '0;
      end else begin
         r_vld     <= {r_vld[PIPE_LAT-2:0], vec_valid};
         r_lst     <= {r_lst[PIPE_LAT-2:0], vec_valid & s_tlast};
         r_ref_vld <= {r_ref_vld[SRT_LAT-2:0], w_tag_vld};
         r_ref_tag <= {r_ref_tag[SRT_LAT-2:0], r_tag};
      end
   end

   assign s_tready  = w_ready;
   assign mat_idx   = (mat_we && (r_state == S_LOAD)) ?
                      4'({r_beat, 2'b00}) : 4'd0;
   assign out_valid = r_vld[PIPE_LAT-1];
   assign out_last  = r_lst[PIPE_LAT-1];
   assign ref_we    = r_ref_vld[SRT_LAT-1];
   assign ref_idx   = ref_we ? r_ref_tag[SRT_LAT-1] : 2'd0;
   assign vec_count = r_vec_count;

endmodule

// File: tb/tb_srt_frame_ctrl.sv
// Bench for srt_frame_ctrl: directed tables, corner sequences and a
// random run against an event-time reference model.
module tb_srt_frame_ctrl;

   localparam int PL = 46;
   localparam int SL = 6;
   localparam int CR = 4;

   logic        aclk = 1'b0;
   logic        areset;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic        mat_we;
   logic [3:0]  mat_idx;
   logic        vec_valid;
   logic        ref_we;
   logic [1:0]  ref_idx;
   logic        out_valid;
   logic        out_last;
   logic        fifo_pop;
   logic        frame_done;
   logic        err_short;
   logic [15:0] vec_count;

   srt_frame_ctrl #(
      .PIPE_LAT (PL),
      .SRT_LAT  (SL),
      .MAT_BEATS(3),
      .CREDITS  (CR),
      .CNT_W    (16)
   ) dut (
      .aclk      (aclk),
      .areset    (areset),
      .s_tvalid  (s_tvalid),
      .s_tlast   (s_tlast),
      .s_tready  (s_tready),
      .mat_we    (mat_we),
      .mat_idx   (mat_idx),
      .vec_valid (vec_valid),
      .ref_we    (ref_we),
      .ref_idx   (ref_idx),
      .out_valid (out_valid),
      .out_last  (out_last),
      .fifo_pop  (fifo_pop),
      .frame_done(frame_done),
      .err_short (err_short),
      .vec_count (vec_count)
   );

   always #5 aclk = ~aclk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: frame phase plus absolute event times.
   int m_cyc, m_hdr, m_mode, m_infl, m_cnt, m_tags, m_lastk;
   int out_at[int];
   int ref_at[int];

   typedef struct {
      bit         v;
      bit         l;
      bit         mw;
      logic [3:0] mi;
      bit         vv;
      bit         rw;
      logic [1:0] ri;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [29:0] dut_b();
      return {s_tready, mat_we, mat_idx, vec_valid, ref_we, ref_idx,
              out_valid, out_last, frame_done, err_short, vec_count};
   endfunction

   task automatic model_reset();
      m_cyc   = 0;
      m_hdr   = 0;
      m_mode  = 0;
      m_infl  = 0;
      m_cnt   = 0;
      m_tags  = 0;
      m_lastk = -1000;
      out_at.delete();
      ref_at.delete();
   endtask

   task automatic model_step(input bit v, input bit l, input bit p);
      bit er, hs, emw, evv, erw, eov, eol, efd, ees, dec;
      logic [3:0]  emi;
      logic [1:0]  eri;
      logic [15:0] evc;
      er  = (m_mode == 0) ? 1'b1 :
            (m_mode == 1) ? (m_infl < CR) : 1'b0;
      hs  = v & er;
      emw = hs && (m_mode == 0);
      emi = emw ? 4'(4 * m_hdr) : 4'd0;
      ees = emw & l;
      evv = hs && (m_mode == 1);
      eov = out_at.exists(m_cyc);
      eol = eov ? (out_at[m_cyc] != 0) : 1'b0;
      erw = ref_at.exists(m_cyc);
      eri = erw ? 2'(ref_at[m_cyc]) : 2'd0;
      efd = (m_mode == 2) && (m_cyc == m_lastk + PL + 1);
      evc = 16'(m_cnt);
      chk($sformatf("model_cyc%0d", m_cyc), 32'(dut_b()),
          32'({er, emw, emi, evv, erw, eri, eov, eol, efd, ees, evc}));
      if (emw) begin
         if (m_hdr == 0) begin
            m_cnt  = 0;
            m_tags = 0;
         end
         if (l) begin
            m_hdr = 0;
         end else begin
            m_hdr++;
            if (m_hdr == 3) begin
               m_hdr  = 0;
               m_mode = 1;
            end
         end
      end
      if (evv) begin
         if (m_cnt < 65535) m_cnt++;
         out_at[m_cyc + PL] = int'(l);
         if (m_tags < 3) begin
            ref_at[m_cyc + SL] = m_tags;
            m_tags++;
         end
         if (l) begin
            m_mode  = 2;
            m_lastk = m_cyc;
         end
      end
      dec = p && (m_infl > 0);
      if (evv && !dec) m_infl++;
      else if (!evv && dec) m_infl--;
      if (efd) m_mode = 0;
      out_at.delete(m_cyc);
      ref_at.delete(m_cyc);
      m_cyc++;
   endtask

   task automatic step(input bit v, input bit l, input bit p);
      @(negedge aclk);
      s_tvalid = v;
      s_tlast  = l;
      fifo_pop = p;
      #1;
      model_step(v, l, p);
   endtask

   initial begin
      int acc;
      int nov;
      int nfd;
      bit v;
      bit l;
      areset   = 1'b1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      fifo_pop = 1'b0;

      tbl[0]  = '{1, 0, 1, 4'd0, 0, 0, 2'd0};
      tbl[1]  = '{1, 0, 1, 4'd4, 0, 0, 2'd0};
      tbl[2]  = '{1, 0, 1, 4'd8, 0, 0, 2'd0};
      tbl[3]  = '{1, 0, 0, 4'd0, 1, 0, 2'd0};
      tbl[4]  = '{1, 0, 0, 4'd0, 1, 0, 2'd0};
      tbl[5]  = '{1, 0, 0, 4'd0, 1, 0, 2'd0};
      tbl[6]  = '{1, 0, 0, 4'd0, 1, 0, 2'd0};
      tbl[7]  = '{1, 1, 0, 4'd0, 1, 0, 2'd0};
      tbl[8]  = '{1, 0, 0, 4'd0, 0, 0, 2'd0};
      tbl[9]  = '{1, 0, 0, 4'd0, 0, 1, 2'd0};
      tbl[10] = '{1, 0, 0, 4'd0, 0, 1, 2'd1};
      tbl[11] = '{1, 0, 0, 4'd0, 0, 1, 2'd2};

      repeat (3) @(negedge aclk);
      #1;
      chk("reset_outputs", 32'(dut_b()), 32'd0);
      areset = 1'b0;
      model_reset();

      // 3 header + 5 vectors, tvalid held, fifo_pop tied high
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].v, tbl[i].l, 1'b1);
         chk($sformatf("f1_tbl_c%0d", i),
             32'({mat_we, mat_idx, vec_valid, ref_we, ref_idx}),
             32'({tbl[i].mw, tbl[i].mi, tbl[i].vv, tbl[i].rw, tbl[i].ri}));
      end
      for (int c = 12; c < 56; c++) begin
         step(c < 55, 1'b0, 1'b1);
         chk($sformatf("f1_out_c%0d", c),
             32'({out_valid, out_last, frame_done, ref_we}),
             32'({(c >= 49) && (c <= 53), c == 53, c == 54, 1'b0}));
      end
      chk("f1_vec_count", 32'(vec_count), 32'd5);

      // credit exhaustion with fifo_pop held low
      repeat (3) step(1'b1, 1'b0, 1'b0);
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 1'b0);
         acc += int'(s_tready);
      end
      chk("cred_accepts", 32'(acc), 32'd4);
      chk("cred_blocked", 32'(s_tready), 32'd0);
      step(1'b1, 1'b0, 1'b1);
      chk("cred_pop_cycle", 32'(s_tready), 32'd0);
      step(1'b1, 1'b0, 1'b0);
      chk("cred_release", 32'(s_tready), 32'd1);
      acc += int'(s_tready);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0);
         acc += int'(s_tready);
      end
      chk("cred_one_more", 32'(acc), 32'd5);

      // simultaneous push and pop at inflight 3
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      chk("simul_ready", 32'(s_tready), 32'd1);
      step(1'b1, 1'b0, 1'b0);
      chk("simul_held3", 32'(s_tready), 32'd1);
      step(1'b1, 1'b0, 1'b0);
      chk("simul_full", 32'(s_tready), 32'd0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      repeat (60) step(1'b0, 1'b0, 1'b1);

      // spare pops at inflight 0 must not create credit
      repeat (3) step(1'b1, 1'b0, 1'b0);
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b0);
         acc += int'(s_tready);
      end
      chk("zero_pop_accepts", 32'(acc), 32'd4);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      repeat (60) step(1'b0, 1'b0, 1'b1);

      // tlast during header beat 1
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("short_err", 32'({err_short, mat_we, mat_idx}),
          32'({1'b1, 1'b1, 4'd4}));
      repeat (3) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("short_reload", 32'({mat_we, mat_idx, err_short}),
          32'({1'b1, 4'd0, 1'b0}));
      repeat (2) step(1'b1, 1'b0, 1'b1);
      repeat (2) step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      repeat (55) step(1'b0, 1'b0, 1'b1);

      // reset with ten vectors in the pipeline
      repeat (3) step(1'b1, 1'b0, 1'b1);
      repeat (10) step(1'b1, 1'b0, 1'b1);
      @(negedge aclk);
      areset   = 1'b1;
      s_tvalid = 1'b1;
      #1;
      chk("rst_ready_low", 32'({s_tready, vec_valid}), 32'd0);
      @(negedge aclk);
      #1;
      chk("rst_all_zero", 32'(dut_b()), 32'd0);
      areset   = 1'b0;
      s_tvalid = 1'b0;
      model_reset();
      nov = 0;
      for (int i = 0; i < 60; i++) begin
         step(1'b0, 1'b0, 1'b1);
         nov += int'(out_valid);
      end
      chk("rst_no_out", 32'(nov), 32'd0);
      nfd = 0;
      nov = 0;
      repeat (3) step(1'b1, 1'b0, 1'b1);
      repeat (2) step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 55; i++) begin
         step(1'b0, 1'b0, 1'b1);
         nfd += int'(frame_done);
         nov += int'(out_valid);
      end
      chk("rst_fresh_done", 32'(nfd), 32'd1);
      chk("rst_fresh_outs", 32'(nov), 32'd3);
      chk("rst_fresh_cnt", 32'(vec_count), 32'd3);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(0, 9) < 7);
         if (m_mode == 0) l = ($urandom_range(0, 19) == 0);
         else             l = ($urandom_range(0, 7) == 0);
         step(v, l, 1'($urandom_range(0, 1)));
      end
      repeat (60) step(1'b0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/srt_frame_ctrl.md
# srt_frame_ctrl

Frame sequencer for the SRT/CORDIC point-processing datapath. Parses each AXIS frame from the DMA MM2S channel into a 3-beat matrix header plus N vector beats. Drives the matrix-load strobes, the vector-valid gate and the reference-point capture window. Tracks beats through the fixed-latency datapath and throttles input with a credit counter sized to the downstream output FIFO, so the S2MM side can apply backpressure without losing data.

## Interface
- PIPE_LAT, 46: cycles from input acceptance to datapath result (shift-register length).
- SRT_LAT, 6: cycles from input acceptance to valid SRT normalize output.
- MAT_BEATS, 3: header beats per frame; 4 matrix words per beat.
- CREDITS, 64: downstream output FIFO depth, in beats.
- CNT_W, 16: width of vec_count.
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_tvalid  in  1  AXIS input valid.
- s_tlast  in  1  AXIS input last.
- s_tready  out  1  AXIS input ready.
- mat_we  out  1  matrix word write enable; datapath captures lanes on the rising edge.
- mat_idx  out  4  base index of the words written this beat: 0, 4 or 8.
- vec_valid  out  1  current beat is a vector beat and is accepted; gates the datapath vector input.
- ref_we  out  1  capture current SRT output as a reference point.
- ref_idx  out  2  reference slot, 0..2.
- out_valid  out  1  datapath result valid; pushes into the output FIFO.
- out_last  out  1  result belongs to the final vector of the frame.
- fifo_pop  in  1  output FIFO consumed one beat; returns one credit.
- frame_done  out  1  one-cycle pulse when the frame is fully drained.
- err_short  out  1  one-cycle pulse when tlast arrives during the header.
- vec_count  out  CNT_W  vector beats accepted in the current or last frame.

## Operation
- Handshake hs = s_tvalid & s_tready. Data transfers only on hs.
- States: IDLE, LOAD, STREAM, DRAIN.
- IDLE:
  - s_tready=1.
  - On hs: mat_we=1, mat_idx=0, clear vec_count, go to LOAD with beat counter=1.
- LOAD:
  - s_tready=1.
  - On hs: mat_we=1, mat_idx=4×beat counter.
  - On hs of beat MAT_BEATS-1: go to STREAM.
- tlast on any header beat (IDLE or LOAD):
  - That beat is still written.
  - err_short pulses; state returns to IDLE.
  - No vector, out_valid or frame_done activity for that frame.
- STREAM:
  - s_tready = (inflight < CREDITS).
  - vec_valid = hs (combinational).
  - On hs: vec_count increments, saturating at all-ones.
  - On hs with tlast: go to DRAIN.
  - s_tready stays 0 while credits are exhausted; the upstream beat is held, not dropped.
- DRAIN:
  - s_tready=0.
  - When the PIPE_LAT shift register is all zero, pulse frame_done and go to IDLE.
- inflight counter:
  - +1 on vector hs; -1 on fifo_pop; unchanged when both occur.
  - fifo_pop at inflight=0 is ignored.
  - Never exceeds CREDITS.
  - Not cleared between frames.
- Pipeline tracking:
  - vld/lst shift registers of length PIPE_LAT shift every cycle.
  - Inputs are vec_valid and (vec_valid & s_tlast).
  - out_valid and out_last are the last taps.
- Reference capture:
  - The first three vector beats of a frame are tagged 0..2.
  - SRT_LAT cycles after each tagged beat is accepted: ref_we=1, ref_idx=tag.
  - Frames with fewer than 3 vectors produce fewer ref_we pulses.
- Reset values (areset=1 on a rising edge): state IDLE, counters 0, shift registers 0.
  - Outputs: s_tready=0 while areset is high; mat_we, vec_valid, ref_we, out_valid, out_last, frame_done, err_short all 0; mat_idx=0; ref_idx=0; vec_count=0.
- Mid-frame reset discards all in-flight results; no out_valid follows.

## Timing
- mat_we, vec_valid and s_tready are combinational from state, registers and s_tvalid. No combinational path from fifo_pop to s_tready; the counter is registered.
- Vector accepted in cycle k:
  - out_valid=1 in cycle k+PIPE_LAT.
  - ref_we in cycle k+SRT_LAT, if the beat is tagged.
- Credit released by fifo_pop in cycle k is usable by s_tready in cycle k+1.
- Last vector accepted in cycle k: out_last in cycle k+PIPE_LAT; frame_done in cycle k+PIPE_LAT+1; IDLE from cycle k+PIPE_LAT+2.
- Header-to-stream: first vector is acceptable in the cycle after header beat MAT_BEATS-1 is accepted.
- Back-to-back frames: none accepted during DRAIN. Minimum inter-frame gap is PIPE_LAT+1 cycles.

## Test plan
- Frame of 3 header + 5 vectors, s_tvalid held high, fifo_pop tied high:
  - mat_we in cycles 0..2 with mat_idx 0, 4, 8.
  - vec_valid in cycles 3..7.
  - out_valid in cycles 49..53; out_last in cycle 53.
  - frame_done in cycle 54; vec_count=5.
- Same frame: ref_we in cycles 9, 10, 11 with ref_idx 0, 1, 2; no further ref_we.
- CREDITS=4, fifo_pop=0, 10 vectors offered:
  - Exactly 4 accepted, then s_tready=0.
  - One fifo_pop pulse in cycle c gives s_tready=1 in cycle c+1 and exactly one more acceptance.
- tlast on header beat 1: err_short pulses in that cycle; state IDLE; no vec_valid or out_valid; the next frame loads from mat_idx 0.
- Simultaneous vector hs and fifo_pop with inflight=3: inflight stays 3. fifo_pop at inflight=0 leaves it at 0.
- areset asserted 10 cycles into STREAM with 10 beats in flight: every output is 0 from the next edge, and no out_valid pulse appears afterwards. A fresh frame then completes normally.
